// File: rtl/ahb_lite_responder_bridge.sv
// AHB-Lite responder endpoint that turns pipelined address/data phases into
// single-beat client requests, with wait states, two-cycle ERROR and byte strobes.
`default_nettype none

module ahb_lite_responder_bridge #(
    parameter int AHB_LITE_ADDR_WIDTH = 32,
    parameter int AHB_LITE_DATA_WIDTH = 32,
    parameter int CLIENT_ADDR_WIDTH   = 16
) (
    input  logic                               hclk,
    input  logic                               hreset_n,
    input  logic [AHB_LITE_ADDR_WIDTH-1:0]     haddr_i,
    input  logic [AHB_LITE_DATA_WIDTH-1:0]     hwdata_i,
    input  logic                               hsel_i,
    input  logic                               hwrite_i,
    input  logic                               hready_i,
    input  logic [1:0]                         htrans_i,
    input  logic [2:0]                         hsize_i,
    output logic                               hresp_o,
    output logic                               hreadyout_o,
    output logic [AHB_LITE_DATA_WIDTH-1:0]     hrdata_o,
    output logic                               dv_o,
    output logic                               write_o,
    output logic [CLIENT_ADDR_WIDTH-1:0]       addr_o,
    output logic [AHB_LITE_DATA_WIDTH-1:0]     wdata_o,
    output logic [AHB_LITE_DATA_WIDTH/8-1:0]   wstrb_o,
    input  logic                               hold_i,
    input  logic [AHB_LITE_DATA_WIDTH-1:0]     rdata_i,
    input  logic                               error_i
);

    localparam int STRB_W = AHB_LITE_DATA_WIDTH / 8;
    localparam int LANE_W = (AHB_LITE_DATA_WIDTH == 64) ? 3 : 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t                        state;
    logic                          accept;
    logic                          take;
    logic                          legal;
    logic                          size_bad;
    logic                          misaligned;
    logic [AHB_LITE_ADDR_WIDTH-1:0] align_mask;
    logic [LANE_W-1:0]             lane;
    logic [STRB_W-1:0]             strb;
    logic                          unused_ok;

    assign unused_ok  = htrans_i[0];

    assign accept     = hsel_i && hready_i && htrans_i[1];
    assign align_mask = (AHB_LITE_ADDR_WIDTH'(1) << hsize_i) - AHB_LITE_ADDR_WIDTH'(1);
    assign misaligned = |(haddr_i & align_mask);
    assign size_bad   = hsize_i > 3'(LANE_W);
    assign legal      = !size_bad && !misaligned;
    assign lane       = haddr_i[LANE_W-1:0];

    // A new address phase is only taken where the previous transfer is finishing
    // cleanly; an address phase overlapping a client error completion is dropped.
    assign take = accept && ((state == ST_IDLE) || (state == ST_ERR2) ||
                             ((state == ST_DATA) && !hold_i && !error_i));

    always_comb begin
        strb = '0;
        for (int i = 0; i < STRB_W; i++) begin
            if ((i >= int'(lane)) && (i < int'(lane) + (1 << int'(hsize_i))))
                strb[i] = 1'b1;
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state   <= ST_IDLE;
            addr_o  <= '0;
            write_o <= 1'b0;
            wstrb_o <= '0;
        end else begin
            if (take) begin
                addr_o  <= haddr_i[CLIENT_ADDR_WIDTH-1:0];
                write_o <= hwrite_i;
                wstrb_o <= strb;
            end
            case (state)
                ST_IDLE: if (take) state <= legal ? ST_DATA : ST_ERR1;
                ST_DATA: begin
                    if (!hold_i) begin
                        if (error_i)   state <= ST_ERR1;
                        else if (take) state <= legal ? ST_DATA : ST_ERR1;
                        else           state <= ST_IDLE;
                    end
                end
                ST_ERR1: state <= ST_ERR2;
                ST_ERR2: state <= take ? (legal ? ST_DATA : ST_ERR1) : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dv_o        = (state == ST_DATA);
    assign hresp_o     = (state == ST_ERR1) || (state == ST_ERR2);
    assign hreadyout_o = (state == ST_DATA) ? !hold_i : (state != ST_ERR1);
    assign hrdata_o    = (dv_o && !write_o && !hold_i) ? rdata_i : '0;
    assign wdata_o     = hwdata_i;

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_responder_bridge.sv
// Directed self-checking bench for ahb_lite_responder_bridge (32-bit data).
`default_nettype none

module tb_ahb_lite_responder_bridge;

    logic        hclk = 1'b0;
    logic        hreset_n;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hsel;
    logic        hwrite;
    logic        hready;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hresp;
    logic        hreadyout;
    logic [31:0] hrdata;
    logic        dv;
    logic        write;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        hold;
    logic [31:0] rdata;
    logic        error;

    int checks = 0;
    int errors = 0;

    // Single-responder system: the decoder's hready is this responder's hreadyout.
    assign hready = hreadyout;

    always #5 hclk = ~hclk;

    ahb_lite_responder_bridge #(
        .AHB_LITE_ADDR_WIDTH(32),
        .AHB_LITE_DATA_WIDTH(32),
        .CLIENT_ADDR_WIDTH(16)
    ) dut (
        .hclk(hclk), .hreset_n(hreset_n), .haddr_i(haddr), .hwdata_i(hwdata),
        .hsel_i(hsel), .hwrite_i(hwrite), .hready_i(hready), .htrans_i(htrans),
        .hsize_i(hsize), .hresp_o(hresp), .hreadyout_o(hreadyout), .hrdata_o(hrdata),
        .dv_o(dv), .write_o(write), .addr_o(addr), .wdata_o(wdata), .wstrb_o(wstrb),
        .hold_i(hold), .rdata_i(rdata), .error_i(error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic addr_phase(input logic wr, input logic [1:0] tr,
                              input logic [31:0] a, input logic [2:0] sz);
        hsel = 1'b1; hwrite = wr; htrans = tr; haddr = a; hsize = sz;
    endtask

    task automatic bus_idle();
        hsel = 1'b0; hwrite = 1'b0; htrans = 2'b00; haddr = '0; hsize = 3'd0;
    endtask

    // Advance to the middle of the next cycle (inputs set afterwards, checks after #1).
    task automatic next_cycle();
        @(negedge hclk);
    endtask

    initial begin
        hreset_n = 1'b0; hold = 1'b0; rdata = '0; error = 1'b0; hwdata = '0;
        bus_idle();
        #2;
        check("rst_hreadyout", 32'(hreadyout), 32'd1);
        check("rst_hresp",     32'(hresp),     32'd0);
        check("rst_dv",        32'(dv),        32'd0);
        check("rst_write",     32'(write),     32'd0);
        check("rst_addr",      32'(addr),      32'd0);
        check("rst_wstrb",     32'(wstrb),     32'd0);
        check("rst_hrdata",    hrdata,         32'd0);
        next_cycle();
        hreset_n = 1'b1;

        // Word write 0x1000, zero wait
        next_cycle();
        addr_phase(1'b1, 2'b10, 32'h1000, 3'd2);
        #1 check("wr_addrphase_ready", 32'(hreadyout), 32'd1);
        next_cycle();
        bus_idle(); hwdata = 32'hDEADBEEF;
        #1;
        check("wr_dv",        32'(dv),        32'd1);
        check("wr_write",     32'(write),     32'd1);
        check("wr_addr",      32'(addr),      32'h1000);
        check("wr_wstrb",     32'(wstrb),     32'hF);
        check("wr_wdata",     wdata,          32'hDEADBEEF);
        check("wr_hreadyout", 32'(hreadyout), 32'd1);
        check("wr_hresp",     32'(hresp),     32'd0);
        check("wr_hrdata",    hrdata,         32'd0);

        // Word read 0x0004 with two hold cycles
        next_cycle();
        addr_phase(1'b0, 2'b10, 32'h0004, 3'd2);
        next_cycle();
        bus_idle(); hold = 1'b1; rdata = 32'h12345678;
        #1;
        check("rd_hold1_ready",  32'(hreadyout), 32'd0);
        check("rd_hold1_dv",     32'(dv),        32'd1);
        check("rd_hold1_hrdata", hrdata,         32'd0);
        next_cycle();
        #1;
        check("rd_hold2_ready",  32'(hreadyout), 32'd0);
        check("rd_hold2_addr",   32'(addr),      32'h0004);
        next_cycle();
        hold = 1'b0;
        #1;
        check("rd_done_ready",  32'(hreadyout), 32'd1);
        check("rd_done_hrdata", hrdata,         32'h12345678);
        check("rd_done_write",  32'(write),     32'd0);

        // Back-to-back write 0x10 then read 0x14
        next_cycle();
        addr_phase(1'b1, 2'b10, 32'h10, 3'd2);
        next_cycle();
        addr_phase(1'b0, 2'b10, 32'h14, 3'd2); hwdata = 32'hCAFEF00D;
        #1;
        check("b2b_1_dv",    32'(dv),        32'd1);
        check("b2b_1_write", 32'(write),     32'd1);
        check("b2b_1_addr",  32'(addr),      32'h10);
        check("b2b_1_ready", 32'(hreadyout), 32'd1);
        next_cycle();
        bus_idle(); rdata = 32'hAABBCCDD;
        #1;
        check("b2b_2_dv",     32'(dv),        32'd1);
        check("b2b_2_write",  32'(write),     32'd0);
        check("b2b_2_addr",   32'(addr),      32'h14);
        check("b2b_2_ready",  32'(hreadyout), 32'd1);
        check("b2b_2_hrdata", hrdata,         32'hAABBCCDD);

        // Misaligned halfword at 0x3, then byte write at 0x2 held through the error
        next_cycle();
        addr_phase(1'b1, 2'b10, 32'h3, 3'd1);
        next_cycle();
        addr_phase(1'b1, 2'b10, 32'h2, 3'd0);
        #1;
        check("mis_err1_dv",    32'(dv),        32'd0);
        check("mis_err1_hresp", 32'(hresp),     32'd1);
        check("mis_err1_ready", 32'(hreadyout), 32'd0);
        next_cycle();
        #1;
        check("mis_err2_dv",    32'(dv),        32'd0);
        check("mis_err2_hresp", 32'(hresp),     32'd1);
        check("mis_err2_ready", 32'(hreadyout), 32'd1);
        next_cycle();
        bus_idle();
        #1;
        check("byte_dv",    32'(dv),    32'd1);
        check("byte_wstrb", 32'(wstrb), 32'b0100);
        check("byte_addr",  32'(addr),  32'h2);
        check("byte_hresp", 32'(hresp), 32'd0);

        // Oversized (doubleword) transfer on a 32-bit bus is illegal
        next_cycle();
        addr_phase(1'b0, 2'b10, 32'h20, 3'd3);
        next_cycle();
        bus_idle();
        #1;
        check("dword_dv",    32'(dv),    32'd0);
        check("dword_hresp", 32'(hresp), 32'd1);
        next_cycle();
        next_cycle();

        // Client error on read completion
        next_cycle();
        addr_phase(1'b0, 2'b10, 32'h8, 3'd2);
        next_cycle();
        bus_idle(); error = 1'b1;
        #1;
        check("cerr_data_dv",    32'(dv),        32'd1);
        check("cerr_data_hresp", 32'(hresp),     32'd0);
        next_cycle();
        error = 1'b0;
        #1;
        check("cerr_err1_hresp", 32'(hresp),     32'd1);
        check("cerr_err1_ready", 32'(hreadyout), 32'd0);
        check("cerr_err1_dv",    32'(dv),        32'd0);
        next_cycle();
        #1;
        check("cerr_err2_hresp", 32'(hresp),     32'd1);
        check("cerr_err2_ready", 32'(hreadyout), 32'd1);
        next_cycle();
        #1;
        check("cerr_idle_hresp", 32'(hresp),     32'd0);
        check("cerr_idle_ready", 32'(hreadyout), 32'd1);
        check("cerr_idle_dv",    32'(dv),        32'd0);

        // BUSY then IDLE with hsel asserted: no client access
        addr_phase(1'b1, 2'b01, 32'h40, 3'd2);
        next_cycle();
        addr_phase(1'b1, 2'b00, 32'h44, 3'd2);
        #1;
        check("busy_dv",    32'(dv),        32'd0);
        check("busy_ready", 32'(hreadyout), 32'd1);
        check("busy_hresp", 32'(hresp),     32'd0);
        next_cycle();
        bus_idle();
        #1;
        check("idle_dv",    32'(dv),        32'd0);
        check("idle_ready", 32'(hreadyout), 32'd1);

        // Asynchronous reset while the client is holding
        addr_phase(1'b1, 2'b10, 32'h0C, 3'd2);
        next_cycle();
        bus_idle(); hold = 1'b1;
        #1;
        check("hrst_pre_dv",    32'(dv),        32'd1);
        check("hrst_pre_ready", 32'(hreadyout), 32'd0);
        hreset_n = 1'b0;
        #1;
        check("hrst_dv",     32'(dv),        32'd0);
        check("hrst_ready",  32'(hreadyout), 32'd1);
        check("hrst_addr",   32'(addr),      32'd0);
        check("hrst_wstrb",  32'(wstrb),     32'd0);
        check("hrst_write",  32'(write),     32'd0);
        check("hrst_hresp",  32'(hresp),     32'd0);
        hold = 1'b0;
        next_cycle();
        hreset_n = 1'b1;
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
